mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Arbitrates one single-port synchronous unified memory between the instruction-fetch port (IF) and the load/store port (LS) of the RV32 core.
- One memory access is issued per cycle.
- LS has fixed priority over IF.
- A starvation guard forces an IF grant after STARVE_MAX consecutive IF denials.
- The block tracks which port owns the in-flight access and routes the read data back to that port one cycle later.

Parameters:
ADDR_W, 32, byte-address width on all ports.
DATA_W, 32, data width.
STARVE_MAX, 4, number of consecutive denied IF cycles after which IF wins (minimum 1).
CNT_W, 3, starvation counter width; must satisfy 2^CNT_W > STARVE_MAX.

Ports:
i_clk  in  1  clock, rising edge.
i_reset  in  1  synchronous, active-low reset.
i_if_req  in  1  IF read request; held high until granted.
i_if_addr  in  ADDR_W  IF byte address.
o_if_gnt  out  1  IF request accepted this cycle (combinational).
o_if_rvalid  out  1  IF read data valid (one cycle after grant).
o_if_rdata  out  DATA_W  IF read data.
i_ls_req  in  1  LS request; held high until granted.
i_ls_we  in  1  1 = write, 0 = read.
i_ls_addr  in  ADDR_W  LS byte address.
i_ls_wdata  in  DATA_W  LS write data.
i_ls_bmask  in  4  LS byte enables, used for writes.
o_ls_gnt  out  1  LS request accepted this cycle (combinational).
o_ls_rvalid  out  1  LS response valid: read data or write acknowledge.
o_ls_rdata  out  DATA_W  LS read data.
o_mem_en  out  1  memory access enable.
o_mem_we  out  1  memory write enable.
o_mem_addr  out  ADDR_W  memory byte address (memory indexes [ADDR_W-1:2]).
o_mem_wdata  out  DATA_W  memory write data.
o_mem_bmask  out  4  memory byte enables.
i_mem_rdata  in  DATA_W  memory read data, valid the cycle after o_mem_en with o_mem_we=0.

Behaviour:
Grant logic (combinational, same cycle as the request):
- force_if = i_if_req && (starve_cnt == STARVE_MAX).
- o_if_gnt = i_if_req && (!i_ls_req || force_if).
- o_ls_gnt = i_ls_req && !o_if_gnt.
- At most one grant per cycle.
- Both grants are 0 while i_reset == 0.

Memory drive:
- o_mem_en = o_if_gnt | o_ls_gnt.
- Address, wdata, bmask and we are muxed from the granted port.
- IF grant forces we = 0 and bmask = 4'b0000.
- With no grant, all memory outputs are 0.

Starvation counter (starve_cnt), registered:
- Reset: 0.
- IF request denied: +1, saturating at STARVE_MAX.
- IF granted or i_if_req = 0: cleared to 0.

Owner register (owner), with states NONE / IF_RD / LS_RD / LS_WR:
- Loaded every cycle from the current grant: IF grant -> IF_RD; LS grant with we=0 -> LS_RD; LS grant with we=1 -> LS_WR; no grant -> NONE.
- Reset: NONE.

Response path (registered through owner):
- o_if_rvalid = (owner == IF_RD).
- o_ls_rvalid = (owner == LS_RD || owner == LS_WR).
- o_if_rdata = i_mem_rdata when o_if_rvalid, else 0.
- o_ls_rdata = i_mem_rdata when owner == LS_RD, else 0. A write acknowledge returns 0.
- Latency: grant in cycle N -> rvalid in cycle N+1.
- Back-to-back grants are allowed; each response belongs to the previous cycle's grant only.

Reset (while i_reset == 0 at a clock edge):
- owner = NONE and starve_cnt = 0.
- All rvalid and rdata outputs are 0 in the following cycle.
- A grant issued in the cycle before reset is asserted gets no response; the pending response is dropped.
- While reset is held, all gnt and mem outputs are 0, regardless of requests.

Boundary conditions:
- Requests that drop before being granted are legal: no grant, no state change except the counter clear.
- Addresses are not checked for alignment; they pass through unchanged.
- STARVE_MAX = 1 gives strict alternation under continuous contention.

Test Plan:
- Reset: i_reset=0 for 2 cycles with both requests high -> gnt=0, o_mem_en=0, both rvalid=0; first cycle after release: o_ls_gnt=1.
- IF-only read: i_if_req=1, addr=0x0000_0010; memory word 4 = 0x0000_0093 -> o_if_gnt=1 and o_mem_addr=0x10 in cycle N; cycle N+1: o_if_rvalid=1, o_if_rdata=0x0000_0093.
- LS write: we=1, addr=0x40, wdata=0xDEADBEEF, bmask=4'b0011 -> o_mem_we=1 and o_mem_bmask=0011 in cycle N; N+1: o_ls_rvalid=1, o_ls_rdata=0.
- Starvation (STARVE_MAX=4), both requests held high continuously -> grant sequence LS,LS,LS,LS,IF,LS,LS,LS,LS,IF; starve_cnt peaks at 4.
- Back-to-back mixed: LS read 0x80 (data 0x11) in cycle N, IF read 0x84 (data 0x22) in N+1 -> N+1: o_ls_rvalid=1, rdata=0x11; N+2: o_if_rvalid=1, rdata=0x22; never both rvalid in one cycle.
- Reset mid-operation: LS read granted in cycle N, i_reset=0 in N+1 -> o_ls_rvalid=0 in N+1 and N+2; owner returns to NONE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between IF and LS ports: LS has priority, a starvation
// counter forces IF through, and an owner register steers the read data back.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 3
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic              o_if_gnt,
   output logic              o_if_rvalid,
   output logic [DATA_W-1:0] o_if_rdata,
   input  logic              i_ls_req,
   input  logic              i_ls_we,
   input  logic [ADDR_W-1:0] i_ls_addr,
   input  logic [DATA_W-1:0] i_ls_wdata,
   input  logic [3:0]        i_ls_bmask,
   output logic              o_ls_gnt,
   output logic              o_ls_rvalid,
   output logic [DATA_W-1:0] o_ls_rdata,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic [3:0]        o_mem_bmask,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   typedef enum logic [1:0] {NONE, IF_RD, LS_RD, LS_WR} owner_t;

   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   owner_t           owner;
   logic [CNT_W-1:0] starve_cnt;
   logic             force_if;

   always_comb begin
      force_if = i_if_req && (starve_cnt == STARVE_LIM);
      o_if_gnt = i_reset && i_if_req && (!i_ls_req || force_if);
      o_ls_gnt = i_reset && i_ls_req && !o_if_gnt;

      o_mem_en    = o_if_gnt || o_ls_gnt;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_mem_bmask = '0;
      if (o_if_gnt) begin
         o_mem_addr = i_if_addr;
      end else if (o_ls_gnt) begin
         o_mem_we    = i_ls_we;
         o_mem_addr  = i_ls_addr;
         o_mem_wdata = i_ls_wdata;
         o_mem_bmask = i_ls_bmask;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         owner      <= NONE;
         starve_cnt <= '0;
      end else begin
         if (o_if_gnt)
            owner <= IF_RD;
         else if (o_ls_gnt)
            owner <= i_ls_we ? LS_WR : LS_RD;
         else
            owner <= NONE;

         if (i_if_req && !o_if_gnt) begin
            if (starve_cnt != STARVE_LIM)
               starve_cnt <= starve_cnt + 1'b1;
         end else begin
            starve_cnt <= '0;
         end
      end
   end

   // Responses are gated by reset so a grant made just before reset is never answered.
   always_comb begin
      o_if_rvalid = i_reset && (owner == IF_RD);
      o_ls_rvalid = i_reset && ((owner == LS_RD) || (owner == LS_WR));
      o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
      o_ls_rdata  = (i_reset && (owner == LS_RD)) ? i_mem_rdata : '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model and a behavioural single-port memory.
module tb_mem_arbiter;

   localparam int SM = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, ls_req, ls_we;
   logic [31:0] if_addr, ls_addr, ls_wdata;
   logic [3:0]  ls_bmask;
   logic        if_gnt, ls_gnt, if_rvalid, ls_rvalid;
   logic [31:0] if_rdata, ls_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_bmask;

   logic [31:0] mem [0:255];

   int errors = 0;
   int checks = 0;

   // reference model state: starvation count and the outstanding response
   int          ref_cnt = 0;
   int          pend = 0;          // 0 none, 1 IF read, 2 LS read, 3 LS write
   logic [31:0] pend_data = '0;

   // last observed values, for directed checks
   logic        o_if_gnt, o_ls_gnt, o_if_rv, o_ls_rv, o_we;
   logic [31:0] o_if_rd, o_ls_rd, o_addr;
   logic [3:0]  o_bm;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM), .CNT_W(3)) dut (
      .i_clk(clk), .i_reset(rst_n),
      .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
      .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
      .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr),
      .i_ls_wdata(ls_wdata), .i_ls_bmask(ls_bmask), .o_ls_gnt(ls_gnt),
      .o_ls_rvalid(ls_rvalid), .o_ls_rdata(ls_rdata),
      .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask), .i_mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // synchronous memory; undriven cycles return junk so ungated rdata shows up
   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_bmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         mem_rdata <= $urandom;
      end else if (mem_en) begin
         mem_rdata <= mem[mem_addr[9:2]];
      end else begin
         mem_rdata <= $urandom;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                       input logic [31:0] la, input logic [31:0] wd, input logic [3:0] bm,
                       input logic rs);
      int          g;   // 0 none, 1 IF, 2 LS
      logic [31:0] e_addr, e_wd;
      logic [3:0]  e_bm;
      logic        e_we;
      @(negedge clk);
      if_req = ir; if_addr = ia; ls_req = lr; ls_we = lw;
      ls_addr = la; ls_wdata = wd; ls_bmask = bm; rst_n = rs;
      #1;
      if (!rs)                      g = 0;
      else if (ir && ref_cnt >= SM) g = 1;
      else if (lr)                  g = 2;
      else if (ir)                  g = 1;
      else                          g = 0;
      e_we = 1'b0; e_addr = '0; e_wd = '0; e_bm = '0;
      if (g == 1) e_addr = ia;
      if (g == 2) begin e_we = lw; e_addr = la; e_wd = wd; e_bm = bm; end

      check("if_gnt", 32'(if_gnt), 32'(g == 1));
      check("ls_gnt", 32'(ls_gnt), 32'(g == 2));
      check("mem_en", 32'(mem_en), 32'(g != 0));
      check("mem_we", 32'(mem_we), 32'(e_we));
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, e_wd);
      check("mem_bmask", 32'(mem_bmask), 32'(e_bm));
      check("if_rvalid", 32'(if_rvalid), 32'(rs && pend == 1));
      check("ls_rvalid", 32'(ls_rvalid), 32'(rs && pend >= 2));
      check("if_rdata", if_rdata, (rs && pend == 1) ? pend_data : 32'h0);
      check("ls_rdata", ls_rdata, (rs && pend == 2) ? pend_data : 32'h0);
      if (if_rvalid && ls_rvalid) check("both_rvalid", 32'd1, 32'd0);

      o_if_gnt = if_gnt; o_ls_gnt = ls_gnt; o_if_rv = if_rvalid; o_ls_rv = ls_rvalid;
      o_if_rd = if_rdata; o_ls_rd = ls_rdata; o_we = mem_we; o_addr = mem_addr; o_bm = mem_bmask;

      // next-cycle model state, computed from the grant decided above
      pend_data = (g == 1) ? mem[ia[9:2]] : (g == 2) ? mem[la[9:2]] : 32'h0;
      pend = (g == 1) ? 1 : (g == 2) ? (lw ? 3 : 2) : 0;
      if (!rs)                 ref_cnt = 0;
      else if (ir && g != 1)   ref_cnt = (ref_cnt < SM) ? ref_cnt + 1 : SM;
      else                     ref_cnt = 0;
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   logic [9:0] seq;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[4]  = 32'h0000_0093;
      mem[32] = 32'h0000_0011;
      mem[33] = 32'h0000_0022;
      rst_n = 0; if_req = 0; ls_req = 0; ls_we = 0;
      if_addr = 0; ls_addr = 0; ls_wdata = 0; ls_bmask = 0;

      // reset held with both requests high, then first cycle after release
      step(1, 32'h100, 1, 0, 32'h200, 0, 0, 0);
      step(1, 32'h100, 1, 0, 32'h200, 0, 0, 0);
      step(1, 32'h100, 1, 0, 32'h200, 0, 0, 1);
      check("post_reset_ls_gnt", 32'(o_ls_gnt), 32'd1);
      idle(2);

      // IF-only read
      step(1, 32'h10, 0, 0, 0, 0, 0, 1);
      check("if_rd_addr", o_addr, 32'h10);
      idle(1);
      check("if_rd_data", o_if_rd, 32'h93);

      // LS write and acknowledge
      step(0, 0, 1, 1, 32'h40, 32'hDEADBEEF, 4'b0011, 1);
      check("ls_wr_we", 32'(o_we), 32'd1);
      check("ls_wr_bmask", 32'(o_bm), 32'b0011);
      idle(1);
      check("ls_wr_ack", 32'(o_ls_rv), 32'd1);
      check("ls_wr_rdata", o_ls_rd, 32'h0);
      check("ls_wr_mem", mem[16], 32'h0000BEEF);

      // starvation under continuous contention
      seq = '0;
      for (int k = 0; k < 10; k++) begin
         step(1, 32'h300 + 32'(4*k), 1, 0, 32'h380, 0, 0, 1);
         seq = {seq[8:0], o_if_gnt};
      end
      check("starve_seq", 32'(seq), 32'b0000100001);
      idle(1);

      // back-to-back LS read then IF read
      step(0, 0, 1, 0, 32'h80, 0, 0, 1);
      step(1, 32'h84, 0, 0, 0, 0, 0, 1);
      check("b2b_ls_rv", 32'(o_ls_rv), 32'd1);
      check("b2b_ls_rd", o_ls_rd, 32'h11);
      idle(1);
      check("b2b_if_rv", 32'(o_if_rv), 32'd1);
      check("b2b_if_rd", o_if_rd, 32'h22);

      // reset right after an LS read grant drops its response
      step(0, 0, 1, 0, 32'h80, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("rst_drop_n1", 32'(o_ls_rv), 32'd0);
      idle(1);
      check("rst_drop_n2", 32'(o_ls_rv), 32'd0);

      // random traffic, occasional resets and unaligned addresses
      for (int n = 0; n < 1500; n++)
         step($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 6,
              $urandom_range(0, 2) == 0, $urandom, $urandom, 4'($urandom),
              $urandom_range(0, 49) != 0);
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
